// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns one local read/write command into a single AXI4-Lite transaction and returns its response.
// Latency: valids rise 1 cycle after iSTART; oDONE pulses in the first IDLE cycle after the response handshake.
// Backpressure: one transaction outstanding, iSTART ignored while busy; a watchdog aborts a slave that stalls any channel.
module axi4_lite_master #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iWRITE,
    input  logic [31:0] iADDR,
    input  logic [31:0] iWDATA,
    input  logic [3:0]  iWSTRB,
    input  logic [2:0]  iPROT,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [31:0] oRDATA,
    output logic [1:0]  oRESP,
    output logic        oTIMEOUT,
    output logic        m_AWVALID,
    output logic [31:0] m_AWADDR,
    output logic [2:0]  m_AWPROT,
    input  logic        m_AWREADY,
    output logic        m_WVALID,
    output logic [31:0] m_WDATA,
    output logic [3:0]  m_WSTRB,
    input  logic        m_WREADY,
    input  logic        m_BVALID,
    input  logic [1:0]  m_BRESP,
    output logic        m_BREADY,
    output logic        m_ARVALID,
    output logic [31:0] m_ARADDR,
    output logic [2:0]  m_ARPROT,
    input  logic        m_ARREADY,
    input  logic        m_RVALID,
    input  logic [31:0] m_RDATA,
    input  logic [1:0]  m_RRESP,
    output logic        m_RREADY
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] wd_cnt;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       strb_q;
    logic [2:0]       prot_q;
    logic             wd_expired;
    logic             finishing;
    logic             aw_done_now;
    logic             w_done_now;

    assign oBUSY     = (state != IDLE);
    assign m_AWADDR  = addr_q;
    assign m_ARADDR  = addr_q;
    assign m_AWPROT  = prot_q;
    assign m_ARPROT  = prot_q;
    assign m_WDATA   = wdata_q;
    assign m_WSTRB   = strb_q;

    // A channel counts as done once its valid has dropped or is handshaking this cycle.
    assign aw_done_now = !m_AWVALID || m_AWREADY;
    assign w_done_now  = !m_WVALID  || m_WREADY;

    // A response landing on the last allowed cycle completes normally instead of aborting.
    assign finishing  = ((state == WR_RESP) && m_BVALID) || ((state == RD_RESP) && m_RVALID);
    assign wd_expired = (TIMEOUT_CYCLES > 0) && (state != IDLE) && (wd_cnt == WD_LAST);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            oDONE     <= 1'b0;
            oRDATA    <= '0;
            oRESP     <= 2'b00;
            oTIMEOUT  <= 1'b0;
            m_AWVALID <= 1'b0;
            m_WVALID  <= 1'b0;
            m_BREADY  <= 1'b0;
            m_ARVALID <= 1'b0;
            m_RREADY  <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            if (state != IDLE) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expired && !finishing) begin
                // Abort: drop every handshake signal even mid-VALID; the system treats this as fatal.
                state     <= IDLE;
                m_AWVALID <= 1'b0;
                m_WVALID  <= 1'b0;
                m_BREADY  <= 1'b0;
                m_ARVALID <= 1'b0;
                m_RREADY  <= 1'b0;
                oRESP     <= 2'b10;
                oTIMEOUT  <= 1'b1;
                oDONE     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (iSTART) begin
                            addr_q   <= iADDR;
                            wdata_q  <= iWDATA;
                            strb_q   <= iWSTRB;
                            prot_q   <= iPROT;
                            oTIMEOUT <= 1'b0;
                            wd_cnt   <= '0;
                            if (iWRITE) begin
                                state     <= WR_REQ;
                                m_AWVALID <= 1'b1;
                                m_WVALID  <= 1'b1;
                            end else begin
                                state     <= RD_REQ;
                                m_ARVALID <= 1'b1;
                            end
                        end
                    end
                    WR_REQ: begin
                        if (m_AWVALID && m_AWREADY) begin
                            m_AWVALID <= 1'b0;
                        end
                        if (m_WVALID && m_WREADY) begin
                            m_WVALID <= 1'b0;
                        end
                        if (aw_done_now && w_done_now) begin
                            state    <= WR_RESP;
                            m_BREADY <= 1'b1;
                        end
                    end
                    WR_RESP: begin
                        if (m_BVALID) begin
                            oRESP    <= m_BRESP;
                            oDONE    <= 1'b1;
                            m_BREADY <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    RD_REQ: begin
                        if (m_ARREADY) begin
                            m_ARVALID <= 1'b0;
                            m_RREADY  <= 1'b1;
                            state     <= RD_RESP;
                        end
                    end
                    RD_RESP: begin
                        if (m_RVALID) begin
                            oRDATA   <= m_RDATA;
                            oRESP    <= m_RRESP;
                            oDONE    <= 1'b1;
                            m_RREADY <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- AXI4-Lite initiator: the master counterpart of the team's axi4_lite_slave.
- Converts single-word commands from a local controller (CPU stub, DMA, testbench driver) into one AXI4-Lite read or write transaction, then returns the response.
- One transaction outstanding at a time; optional watchdog prevents a hung slave from stalling the local side.

Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed in any non-IDLE state before abort; 0 disables the watchdog.
- CNT_W, 16: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- iCLK in 1: clock, all logic on the rising edge.
- iRST in 1: asynchronous, active-low reset.
- iSTART in 1: command request; sampled only in IDLE.
- iWRITE in 1: 1 = write, 0 = read; sampled with iSTART.
- iADDR in 32: transaction address.
- iWDATA in 32: write data.
- iWSTRB in 4: write byte strobes.
- iPROT in 3: protection bits, driven onto AWPROT/ARPROT.
- oBUSY out 1: state != IDLE.
- oDONE out 1: one-cycle completion pulse.
- oRDATA out 32: captured read data; held until the next read completes.
- oRESP out 2: captured BRESP or RRESP.
- oTIMEOUT out 1: set together with oDONE when the watchdog aborted the transaction.
- m_AWVALID out 1, m_AWADDR out 32, m_AWPROT out 3, m_AWREADY in 1: write address channel.
- m_WVALID out 1, m_WDATA out 32, m_WSTRB out 4, m_WREADY in 1: write data channel.
- m_BVALID in 1, m_BRESP in 2, m_BREADY out 1: write response channel.
- m_ARVALID out 1, m_ARADDR out 32, m_ARPROT out 3, m_ARREADY in 1: read address channel.
- m_RVALID in 1, m_RDATA in 32, m_RRESP in 2, m_RREADY out 1: read data channel.

Behaviour:
- Reset (iRST low, asynchronous):
  - state = IDLE.
  - All m_*VALID, m_BREADY, m_RREADY, oDONE, oTIMEOUT = 0.
  - oRDATA = 0; oRESP = 2'b00; address/data/strb/prot registers = 0.
  - Reset mid-transaction drops every valid/ready immediately.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - On iSTART=1, latch iADDR/iWDATA/iWSTRB/iPROT.
  - Go to WR_REQ if iWRITE=1, else RD_REQ.
  - Valids rise the cycle after iSTART (latency 1).
  - iSTART while oBUSY=1 is ignored.
- WR_REQ:
  - m_AWVALID and m_WVALID assert together.
  - Each deasserts independently the cycle after its own VALID&READY handshake; AW may complete before W or the reverse.
  - Address, data, strb and prot stay stable while the corresponding VALID is high.
  - Once both handshakes are done (same cycle or different cycles), go to WR_RESP.
- WR_RESP:
  - m_BREADY = 1. m_BVALID arriving earlier is not accepted, because m_BREADY is low.
  - On m_BVALID&m_BREADY: oRESP <= m_BRESP, oDONE pulses, go to IDLE, m_BREADY drops.
- RD_REQ:
  - m_ARVALID = 1 until m_ARREADY; then go to RD_RESP.
- RD_RESP:
  - m_RREADY = 1.
  - On m_RVALID: oRDATA <= m_RDATA, oRESP <= m_RRESP, oDONE pulses, go to IDLE.
- oDONE timing: oDONE is high in the first IDLE cycle. iSTART in that same cycle is accepted, giving back-to-back transactions with no gap.
- Watchdog:
  - Counter clears on IDLE exit and increments each non-IDLE cycle.
  - When the counter reaches TIMEOUT_CYCLES: all valids/readies drop, oRESP <= 2'b10, oTIMEOUT = 1 with oDONE, go to IDLE.
  - oRDATA is unchanged on a timed-out read.
  - Abort is a deliberate recovery deviation from AXI VALID-stability; the system treats it as fatal.
- oTIMEOUT clears on the next iSTART acceptance.
- Slave responses 2'b01/2'b10/2'b11 are passed through unaltered; the master never retries.

Test Plan:
- Write: iADDR=0x0000_0010, iWDATA=0xDEAD_BEEF, iWSTRB=4'hF; slave asserts AWREADY and WREADY at cycle 2, BVALID with BRESP=00 at cycle 4 -> AW/W seen once with exact values, oDONE pulses one cycle, oRESP=00.
- Skewed write: WREADY 3 cycles after AWREADY -> m_AWVALID drops after AW handshake while m_WVALID stays high; m_BREADY rises only after the W handshake.
- Read: iADDR=0x24; slave gives ARREADY after 2 cycles, then RVALID with RDATA=0x1234_5678, RRESP=00 -> oRDATA=0x1234_5678, oDONE single pulse, oBUSY low the same cycle.
- Back-to-back: write then read with iSTART held high -> read ARVALID rises the cycle after the write's oDONE; both complete with correct data.
- Timeout, TIMEOUT_CYCLES=8: slave never asserts ARREADY -> after 8 busy cycles m_ARVALID=0, oDONE=1, oTIMEOUT=1, oRESP=10, oRDATA unchanged.
- Reset mid-write (iRST low while m_WVALID=1) -> all outputs go to reset values without a clock edge; the next command completes normally.
